i2s_adc_frame_rx: RTL and testbench

Receives the codec's serial ADC stream (left-justified, codec is clock master) and assembles 16-bit left/right samples into 32-bit {L,R} frames. Frames are buffered in a small FIFO and presented on a valid/ready interface. The block sits between the codec pins and the effect chain (echo, low/high/mid-pass) that feeds the DAC serializer. It also reports overflow and framing errors.

---
 rtl/audio_pkg.sv | 17 +
 rtl/sample_fifo.sv | 66 ++++++
 rtl/i2s_adc_frame_rx.sv | 160 ++++++++++++++++
 tb/tb_i2s_adc_frame_rx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and the ADC receive state encoding.
package audio_pkg;

  localparam int unsigned SAMPLE_W_DEF   = 16;
  localparam int unsigned FRAME_W        = 2 * SAMPLE_W_DEF;
  localparam int unsigned BCLK_PER_FRAME = 64;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SHIFT_L,
    WAIT_R,
    SHIFT_R,
    WAIT_L
  } rx_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head data and flags.
module sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             pop;
  logic             wr;
  logic [WIDTH-1:0] head_nxt;

  assign pop        = rd_en && rd_valid;
  assign wr         = wr_en && (!full || pop);
  assign rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign count_nxt  = count + CNT_W'(wr) - CNT_W'(pop);

  // A write landing in the slot that becomes the head must be forwarded into the head register.
  assign head_nxt = (wr && (rd_ptr_nxt == wr_ptr)) ? wr_data : mem[rd_ptr_nxt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_data  <= head_nxt;
      rd_valid <= (count_nxt != '0);
      full     <= (count_nxt == CNT_W'(DEPTH));
      empty    <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/i2s_adc_frame_rx.sv
// Left-justified codec ADC receiver: assembles {L,R} sample frames, buffers them
// in a small FIFO and reports dropped frames and short channel slots.
module i2s_adc_frame_rx
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic        LEFT_LEVEL = 1'b1
) (
  input  logic                  AUD_BCLK,
  input  logic                  rst,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  input  logic                  enable,
  input  logic                  err_clr,
  output logic [2*SAMPLE_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  sync_err,
  output logic [15:0]           frame_count
);

  localparam int unsigned FW    = 2 * SAMPLE_W;
  localparam int unsigned CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  rx_state_e           state;
  rx_state_e           state_nxt;
  logic                lrck_q;
  logic [SAMPLE_W-1:0] sh;
  logic [SAMPLE_W-1:0] sh_nxt;
  logic [SAMPLE_W-1:0] sh_in;
  logic [SAMPLE_W-1:0] left_q;
  logic [SAMPLE_W-1:0] left_nxt;
  logic [CNT_W-1:0]    bitcnt;
  logic [CNT_W-1:0]    bitcnt_nxt;
  logic                lr_edge;
  logic                to_left;
  logic                push;
  logic                short_slot;
  logic                pop;
  logic                accept;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FW-1:0]       frame;

  assign lr_edge = (AUD_ADCLRCK != lrck_q);
  assign to_left = (AUD_ADCLRCK == LEFT_LEVEL);
  assign sh_in   = {sh[SAMPLE_W-2:0], AUD_ADCDAT};
  assign frame   = {left_q, sh_in};
  assign pop     = out_ready && !fifo_empty;
  assign accept  = push && (!fifo_full || pop);

  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lrck_q      <= ~LEFT_LEVEL;
      sh          <= '0;
      left_q      <= '0;
      bitcnt      <= '0;
      overflow    <= 1'b0;
      sync_err    <= 1'b0;
      frame_count <= '0;
    end else begin
      state    <= state_nxt;
      lrck_q   <= AUD_ADCLRCK;
      sh       <= sh_nxt;
      left_q   <= left_nxt;
      bitcnt   <= bitcnt_nxt;
      // New error events win over a coincident clear.
      overflow <= (push && !accept) || (overflow && !err_clr);
      sync_err <= short_slot || (sync_err && !err_clr);
      if (accept) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Slot tracking: the MSB arrives in the LRCK edge cycle, then one bit per BCLK.
  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh;
    left_nxt   = left_q;
    bitcnt_nxt = bitcnt;
    push       = 1'b0;
    short_slot = 1'b0;
    if (!enable) begin
      state_nxt  = IDLE;
      bitcnt_nxt = '0;
    end else begin
      case (state)
        IDLE: state_nxt = SYNC;
        SYNC: begin
          if (lr_edge && to_left) begin
            sh_nxt     = SAMPLE_W'(AUD_ADCDAT);
            bitcnt_nxt = CNT_W'(1);
            state_nxt  = SHIFT_L;
          end
        end
        SHIFT_L, SHIFT_R: begin
          if (lr_edge) begin
            // Slot ended early: drop the partial frame, resync on a left edge.
            short_slot = 1'b1;
            bitcnt_nxt = '0;
            state_nxt  = SYNC;
            if (to_left) begin
              sh_nxt     = SAMPLE_W'(AUD_ADCDAT);
              bitcnt_nxt = CNT_W'(1);
              state_nxt  = SHIFT_L;
            end
          end else begin
            sh_nxt     = sh_in;
            bitcnt_nxt = bitcnt + CNT_W'(1);
            if (bitcnt == LAST_BIT) begin
              if (state == SHIFT_L) begin
                left_nxt  = sh_in;
                state_nxt = WAIT_R;
              end else begin
                push      = 1'b1;
                state_nxt = WAIT_L;
              end
            end
          end
        end
        WAIT_R: begin
          if (lr_edge) begin
            sh_nxt     = SAMPLE_W'(AUD_ADCDAT);
            bitcnt_nxt = CNT_W'(1);
            state_nxt  = SHIFT_R;
          end
        end
        WAIT_L: begin
          if (lr_edge) begin
            sh_nxt     = SAMPLE_W'(AUD_ADCDAT);
            bitcnt_nxt = CNT_W'(1);
            state_nxt  = SHIFT_L;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (AUD_BCLK),
    .rst      (rst),
    .wr_en    (accept),
    .wr_data  (frame),
    .rd_en    (pop),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_i2s_adc_frame_rx.sv
// Scoreboard bench for i2s_adc_frame_rx: drives codec-style serial frames and
// checks popped frames, flags and the frame counter.
module tb_i2s_adc_frame_rx;

  localparam logic LEFT = 1'b1;

  logic        AUD_BCLK = 1'b0;
  logic        rst = 1'b0;
  logic        AUD_ADCLRCK = ~LEFT;
  logic        AUD_ADCDAT = 1'b0;
  logic        enable = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic        sync_err;
  logic [15:0] frame_count;

  int          errors = 0;
  int          checks = 0;
  int          pops_seen = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_f;

  i2s_adc_frame_rx #(
    .SAMPLE_W   (16),
    .FIFO_DEPTH (4),
    .LEFT_LEVEL (LEFT)
  ) dut (
    .AUD_BCLK    (AUD_BCLK),
    .rst         (rst),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .enable      (enable),
    .err_clr     (err_clr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .sync_err    (sync_err),
    .frame_count (frame_count)
  );

  always #5 AUD_BCLK = ~AUD_BCLK;

  // Scoreboard: every accepted pop is compared against the oldest expected frame.
  always @(negedge AUD_BCLK) begin
    #1;
    if (rst && out_valid && out_ready) begin
      pops_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got %h, expected no frame", out_data);
      end else begin
        exp_f = exp_q.pop_front();
        if (out_data !== exp_f) begin
          errors++;
          $display("FAIL frame_data: got %h, expected %h", out_data, exp_f);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_slot(input logic lvl, input logic [15:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge AUD_BCLK);
      AUD_ADCLRCK = lvl;
      AUD_ADCDAT  = (i < 16) ? d[15-i] : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input bit expect_push, input bit pop_on_push);
    if (expect_push) exp_q.push_back({l, r});
    send_slot(LEFT, l, 32);
    for (int i = 0; i < 32; i++) begin
      @(negedge AUD_BCLK);
      AUD_ADCLRCK = ~LEFT;
      AUD_ADCDAT  = (i < 16) ? r[15-i] : 1'($urandom_range(0, 1));
      if (pop_on_push) out_ready = (i == 15);
    end
  endtask

  task automatic apply_reset();
    @(negedge AUD_BCLK);
    rst = 1'b0;
    AUD_ADCLRCK = ~LEFT;
    AUD_ADCDAT = 1'b0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    exp_q.delete();
    pops_seen = 0;
    repeat (2) @(negedge AUD_BCLK);
    rst = 1'b1;
    repeat (3) @(negedge AUD_BCLK);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge AUD_BCLK);
      if (!out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    @(negedge AUD_BCLK);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, overflow, sync_err} !== 3'b000 || frame_count !== 16'd0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b ovf=%b serr=%b cnt=%0d data=%h, expected all 0",
               out_valid, overflow, sync_err, frame_count, out_data);
    end
    apply_reset();
  endtask

  task automatic test_single_frame();
    apply_reset();
    out_ready = 1'b1;
    exp_q.push_back(32'h80017FFE);
    send_slot(LEFT, 16'h8001, 32);
    send_slot(~LEFT, 16'h7FFE, 16);
    @(negedge AUD_BCLK);
    AUD_ADCDAT = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h80017FFE) begin
      errors++;
      $display("FAIL single_latency: got valid=%b data=%h, expected valid=1 data=80017ffe", out_valid, out_data);
    end
    @(negedge AUD_BCLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_pulse: got valid=%b, expected 0", out_valid);
    end
    send_slot(~LEFT, 16'h0000, 14);
    checks++;
    if (frame_count !== 16'd1 || overflow !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL single_status: got cnt=%0d ovf=%b serr=%b, expected cnt=1 ovf=0 serr=0",
               frame_count, overflow, sync_err);
    end
    checks++;
    if (pops_seen !== 1) begin
      errors++;
      $display("FAIL single_pops: got %0d, expected 1", pops_seen);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [15:0] nv;
    apply_reset();
    for (int n = 1; n <= 5; n++) begin
      nv = 16'(n);
      send_frame(nv, ~nv, n <= 4, 1'b0);
    end
    checks++;
    if (overflow !== 1'b1 || frame_count !== 16'd4) begin
      errors++;
      $display("FAIL overflow_status: got ovf=%b cnt=%0d, expected ovf=1 cnt=4", overflow, frame_count);
    end
    @(negedge AUD_BCLK);
    err_clr = 1'b1;
    @(negedge AUD_BCLK);
    err_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got ovf=%b, expected 0", overflow);
    end
    drain(ok);
    checks++;
    if (!ok || pops_seen !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL overflow_drain: got drained=%b pops=%0d left=%0d, expected drained=1 pops=4 left=0",
               ok, pops_seen, exp_q.size());
    end
  endtask

  task automatic test_short_slot();
    apply_reset();
    out_ready = 1'b1;
    send_slot(LEFT, 16'hFFFF, 10);
    send_slot(~LEFT, 16'h5555, 32);
    checks++;
    if (sync_err !== 1'b1 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL short_detect: got serr=%b cnt=%0d, expected serr=1 cnt=0", sync_err, frame_count);
    end
    send_frame(16'h1234, 16'hABCD, 1'b1, 1'b0);
    checks++;
    if (frame_count !== 16'd1 || pops_seen !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL short_recover: got cnt=%0d pops=%0d left=%0d, expected cnt=1 pops=1 left=0",
               frame_count, pops_seen, exp_q.size());
    end
    @(negedge AUD_BCLK);
    err_clr = 1'b1;
    @(negedge AUD_BCLK);
    err_clr = 1'b0;
    checks++;
    if (sync_err !== 1'b0) begin
      errors++;
      $display("FAIL short_clear: got serr=%b, expected 0", sync_err);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    apply_reset();
    send_frame(16'h1111, 16'h2222, 1'b1, 1'b0);
    send_frame(16'h3333, 16'h4444, 1'b1, 1'b0);
    send_slot(LEFT, 16'hDEAD, 32);
    send_slot(~LEFT, 16'hBEEF, 8);
    enable = 1'b0;
    send_slot(~LEFT, 16'hF0F0, 24);
    send_slot(LEFT, 16'h0F0F, 4);
    enable = 1'b1;
    send_slot(LEFT, 16'hAAAA, 28);
    send_slot(~LEFT, 16'hCCCC, 32);
    send_frame(16'h5678, 16'h9ABC, 1'b1, 1'b0);
    checks++;
    if (frame_count !== 16'd3 || sync_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL enable_status: got cnt=%0d serr=%b ovf=%b, expected cnt=3 serr=0 ovf=0",
               frame_count, sync_err, overflow);
    end
    drain(ok);
    checks++;
    if (!ok || pops_seen !== 3 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL enable_drain: got drained=%b pops=%0d left=%0d, expected drained=1 pops=3 left=0",
               ok, pops_seen, exp_q.size());
    end
  endtask

  task automatic test_full_push_pop();
    bit ok;
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      send_frame(16'(16'hA000 + n), 16'(16'h0B00 + n), 1'b1, 1'b0);
    end
    send_frame(16'hC0DE, 16'hFACE, 1'b1, 1'b1);
    checks++;
    if (overflow !== 1'b0 || frame_count !== 16'd5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop: got ovf=%b cnt=%0d valid=%b, expected ovf=0 cnt=5 valid=1",
               overflow, frame_count, out_valid);
    end
    drain(ok);
    checks++;
    if (!ok || pops_seen !== 5 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL full_drain: got drained=%b pops=%0d left=%0d, expected drained=1 pops=5 left=0",
               ok, pops_seen, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      send_frame(16'(16'h0100 * n), 16'(16'h00F0 + n), 1'b1, 1'b0);
    end
    send_slot(LEFT, 16'h5A5A, 8);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || frame_count !== 16'd0 || overflow !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b cnt=%0d ovf=%b serr=%b, expected all 0",
               out_valid, frame_count, overflow, sync_err);
    end
    apply_reset();
    send_frame(16'hFEDC, 16'h0123, 1'b1, 1'b0);
    drain(ok);
    checks++;
    if (!ok || pops_seen !== 1 || exp_q.size() !== 0 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL midreset_recover: got drained=%b pops=%0d left=%0d cnt=%0d, expected 1 1 0 1",
               ok, pops_seen, exp_q.size(), frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_short_slot();
    test_enable_drop();
    test_full_push_pop();
    test_reset_mid_frame();
    repeat (4) @(negedge AUD_BCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
